// File: rtl/mem_port_arbiter.sv
// Shares one 8-bit memory port between instruction fetch and load/store.
// Data requests have priority; a streak limit keeps fetch from starving.
module mem_port_arbiter #(
  parameter int unsigned MEM_WAIT   = 1,
  parameter int unsigned MAX_STREAK = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       f_req,
  input  logic [7:0] f_addr,
  output logic       f_grant,
  output logic       f_valid,
  output logic [7:0] f_rdata,
  input  logic       d_req,
  input  logic       d_write,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic       d_grant,
  output logic       d_valid,
  output logic [7:0] d_rdata,
  output logic [7:0] address,
  output logic [7:0] to_mem,
  input  logic [7:0] from_mem,
  output logic       mem_clock,
  output logic       mem_write
);

  localparam logic [3:0] WAIT_LOAD  = 4'(MEM_WAIT);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT} state_t;
  typedef enum logic {OWN_F, OWN_D} owner_t;

  state_t     state_q, state_d;
  owner_t     owner_q, owner_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] streak_q, streak_d;
  logic [7:0] address_q, address_d;
  logic [7:0] to_mem_q, to_mem_d;
  logic       mem_clock_q, mem_clock_d;
  logic       mem_write_q, mem_write_d;
  logic       f_grant_q, f_grant_d;
  logic       d_grant_q, d_grant_d;
  logic       f_valid_q, f_valid_d;
  logic       d_valid_q, d_valid_d;
  logic [7:0] f_rdata_q, f_rdata_d;
  logic [7:0] d_rdata_q, d_rdata_d;
  logic       pick_data;

  // Fetch only overrides a competing data request once the streak is exhausted.
  assign pick_data = d_req && !(f_req && (streak_q == STREAK_MAX));

  always_comb begin
    // NOTE: every next-state value gets a default first so no path infers a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    wait_d      = wait_q;
    streak_d    = streak_q;
    address_d   = address_q;
    to_mem_d    = to_mem_q;
    mem_write_d = mem_write_q;
    mem_clock_d = 1'b0;
    f_grant_d   = 1'b0;
    d_grant_d   = 1'b0;
    f_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (!f_req) streak_d = '0;
        if (f_req || d_req) begin
          state_d     = S_STROBE;
          mem_clock_d = 1'b1;
          if (pick_data) begin
            owner_d     = OWN_D;
            address_d   = d_addr;
            mem_write_d = d_write;
            to_mem_d    = d_wdata;
            d_grant_d   = 1'b1;
            if (f_req && (streak_q < STREAK_MAX)) streak_d = streak_q + 4'd1;
          end else begin
            owner_d     = OWN_F;
            address_d   = f_addr;
            mem_write_d = 1'b0;
            f_grant_d   = 1'b1;
            streak_d    = '0;
          end
        end
      end
      S_STROBE: begin
        state_d = S_WAIT;
        wait_d  = WAIT_LOAD;
      end
      S_WAIT: begin
        if (wait_q == 4'd1) begin
          state_d = S_IDLE;
          if (owner_q == OWN_D) begin
            d_valid_d = 1'b1;
            if (!mem_write_q) d_rdata_d = from_mem;
          end else begin
            f_valid_d = 1'b1;
            f_rdata_d = from_mem;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_F;
      wait_q      <= '0;
      streak_q    <= '0;
      address_q   <= '0;
      to_mem_q    <= '0;
      mem_clock_q <= 1'b0;
      mem_write_q <= 1'b0;
      f_grant_q   <= 1'b0;
      d_grant_q   <= 1'b0;
      f_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wait_q      <= wait_d;
      streak_q    <= streak_d;
      address_q   <= address_d;
      to_mem_q    <= to_mem_d;
      mem_clock_q <= mem_clock_d;
      mem_write_q <= mem_write_d;
      f_grant_q   <= f_grant_d;
      d_grant_q   <= d_grant_d;
      f_valid_q   <= f_valid_d;
      d_valid_q   <= d_valid_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign f_grant   = f_grant_q;
  assign d_grant   = d_grant_q;
  assign f_valid   = f_valid_q;
  assign d_valid   = d_valid_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign address   = address_q;
  assign to_mem    = to_mem_q;
  assign mem_clock = mem_clock_q;
  assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push expected grants
// and completions; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  localparam int MW = 2;
  localparam int MS = 3;

  typedef struct packed {
    logic       is_d;
    logic [7:0] rdata;
  } exp_t;

  logic       clock, reset;
  logic       f_req, d_req, d_write;
  logic [7:0] f_addr, d_addr, d_wdata;
  logic       f_grant, d_grant, f_valid, d_valid;
  logic [7:0] f_rdata, d_rdata, address, to_mem, from_mem;
  logic       mem_clock, mem_write;

  logic       f_grant_w1, d_grant_w1, f_valid_w1, d_valid_w1;
  logic [7:0] f_rdata_w1, d_rdata_w1, address_w1, to_mem_w1, from_mem_w1;
  logic       mem_clock_w1, mem_write_w1;

  logic [7:0] mem [256];
  exp_t       sb[$];
  logic       gq[$];
  exp_t       mon_e;
  logic       mon_g;
  int         total = 0;
  int         bad   = 0;

  mem_port_arbiter #(.MEM_WAIT(MW), .MAX_STREAK(MS)) u_dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_grant(f_grant), .f_valid(f_valid), .f_rdata(f_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_valid(d_valid), .d_rdata(d_rdata),
    .address(address), .to_mem(to_mem), .from_mem(from_mem),
    .mem_clock(mem_clock), .mem_write(mem_write)
  );

  // Minimum-wait instance; shares stimulus and memory contents, checked only on the first fetch.
  mem_port_arbiter #(.MEM_WAIT(1), .MAX_STREAK(MS)) u_dut_w1 (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_grant(f_grant_w1), .f_valid(f_valid_w1), .f_rdata(f_rdata_w1),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant_w1), .d_valid(d_valid_w1), .d_rdata(d_rdata_w1),
    .address(address_w1), .to_mem(to_mem_w1), .from_mem(from_mem_w1),
    .mem_clock(mem_clock_w1), .mem_write(mem_write_w1)
  );

  assign from_mem    = mem[address];
  assign from_mem_w1 = mem[address_w1];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // mem_clock is high for exactly one cycle per access, so this writes once per strobe.
  always @(negedge clock) begin
    if (!reset && mem_clock && mem_write) mem[address] <= to_mem;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (f_grant || d_grant) begin
        check("grants exclusive", 32'(f_grant & d_grant), 32'd0);
        if (gq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected grant: f_grant=%0b d_grant=%0b expected none at %0t", f_grant, d_grant, $time);
        end else begin
          mon_g = gq.pop_front();
          check("grant owner", 32'(d_grant), 32'(mon_g));
        end
      end
      if (f_valid || d_valid) begin
        check("valids exclusive", 32'(f_valid & d_valid), 32'd0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected valid: f_valid=%0b d_valid=%0b expected none at %0t", f_valid, d_valid, $time);
        end else begin
          mon_e = sb.pop_front();
          check("valid owner", 32'(d_valid), 32'(mon_e.is_d));
          check(mon_e.is_d ? "d_rdata" : "f_rdata", 32'(mon_e.is_d ? d_rdata : f_rdata), 32'(mon_e.rdata));
        end
      end
    end
  end

  // Called #1 after a rising edge with the arbiter idle; returns #1 after the edge ending the valid cycle.
  task automatic access(input logic is_d, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rd);
    sb.push_back(exp_t'{is_d, exp_rd});
    gq.push_back(is_d);
    if (is_d) begin
      d_req = 1'b1; d_write = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    @(posedge clock); #1;
    f_req = 1'b0;
    d_req = 1'b0;
    @(negedge clock);
    check("acc grant", 32'(is_d ? d_grant : f_grant), 32'd1);
    check("acc strobe high", 32'(mem_clock), 32'd1);
    check("acc address", 32'(address), 32'(addr));
    check("acc mem_write", 32'(mem_write), 32'(is_d & wr));
    if (is_d && wr) check("acc to_mem", 32'(to_mem), 32'(wdata));
    @(negedge clock);
    check("acc strobe low", 32'(mem_clock), 32'd0);
    repeat (MW - 1) @(negedge clock);
    check("acc valid early", 32'(is_d ? d_valid : f_valid), 32'd0);
    @(negedge clock);
    check("acc valid on time", 32'(is_d ? d_valid : f_valid), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sb.size() > 0; i++) begin
      @(negedge clock); #1;
    end
    check({"drain ", name}, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_grants(input string name);
    for (int i = 0; i < 200 && gq.size() > 0; i++) begin
      @(negedge clock); #1;
    end
    check({"grants ", name}, 32'(gq.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h30] = 8'h5A;
    mem[8'h40] = 8'h55;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset data outs", {address, to_mem, f_rdata, d_rdata}, 32'd0);
    check("reset strobes", 32'({mem_clock, mem_write, f_grant, d_grant, f_valid, d_valid}), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Single fetch of 0x10 on both instances; MEM_WAIT=1 finishes in cycle 3, MEM_WAIT=2 in cycle 4.
    sb.push_back(exp_t'{1'b0, 8'hA5});
    gq.push_back(1'b0);
    f_req = 1'b1; f_addr = 8'h10;
    @(posedge clock); #1;
    f_req = 1'b0;
    @(negedge clock);
    check("w1 f_grant", 32'(f_grant_w1), 32'd1);
    check("w1 strobe high", 32'(mem_clock_w1), 32'd1);
    check("fetch address", 32'(address), 32'h10);
    check("fetch mem_write", 32'(mem_write), 32'd0);
    @(negedge clock);
    check("w1 strobe low", 32'(mem_clock_w1), 32'd0);
    check("w1 f_valid early", 32'(f_valid_w1), 32'd0);
    @(negedge clock);
    check("w1 f_valid", 32'(f_valid_w1), 32'd1);
    check("w1 f_rdata", 32'(f_rdata_w1), 32'hA5);
    check("f_valid early", 32'(f_valid), 32'd0);
    @(negedge clock);
    check("f_valid on time", 32'(f_valid), 32'd1);
    check("w1 f_valid one cycle", 32'(f_valid_w1), 32'd0);
    @(posedge clock); #1;

    // Store 0x3C to 0x20 leaves d_rdata at its reset value; load reads it back.
    access(1'b1, 1'b1, 8'h20, 8'h3C, 8'h00);
    check("mem after store", 32'(mem[8'h20]), 32'h3C);
    access(1'b1, 1'b0, 8'h20, 8'h00, 8'h3C);

    // Withdrawn store pulsed while a fetch of 0x30 is in WAIT.
    sb.push_back(exp_t'{1'b0, 8'h5A});
    gq.push_back(1'b0);
    f_req = 1'b1; f_addr = 8'h30;
    @(posedge clock); #1;
    f_req = 1'b0;
    @(posedge clock); #1;
    d_req = 1'b1; d_write = 1'b1; d_addr = 8'h40; d_wdata = 8'hEE;
    @(posedge clock); #1;
    d_req = 1'b0; d_write = 1'b0;
    wait_drain("withdrawn");
    @(posedge clock); #1;
    check("mem untouched by withdrawn", 32'(mem[8'h40]), 32'h55);
    access(1'b1, 1'b0, 8'h40, 8'h00, 8'h55);

    // Reset during WAIT abandons the access: all outputs cleared, no valid.
    gq.push_back(1'b0);
    f_req = 1'b1; f_addr = 8'h10;
    @(posedge clock); #1;
    f_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid reset data outs", {address, to_mem, f_rdata, d_rdata}, 32'd0);
    check("mid reset strobes", 32'({mem_clock, mem_write, f_grant, d_grant, f_valid, d_valid}), 32'd0);
    repeat (6) @(posedge clock);
    #1;
    access(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);

    // Continuous contention: D,D,D,F,D,D,D,F.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        gq.push_back(1'b1);
        sb.push_back(exp_t'{1'b1, 8'h3C});
      end
      gq.push_back(1'b0);
      sb.push_back(exp_t'{1'b0, 8'hA5});
    end
    f_req = 1'b1; f_addr = 8'h10;
    d_req = 1'b1; d_write = 1'b0; d_addr = 8'h20;
    wait_grants("contention");
    f_req = 1'b0; d_req = 1'b0;
    wait_drain("contention");
    @(posedge clock); #1;

    // Two data grants under contention, then an idle edge with f_req=0 clears the streak.
    gq.push_back(1'b1); sb.push_back(exp_t'{1'b1, 8'h3C});
    gq.push_back(1'b1); sb.push_back(exp_t'{1'b1, 8'h3C});
    f_req = 1'b1; d_req = 1'b1;
    wait_grants("streak build");
    f_req = 1'b0; d_req = 1'b0;
    wait_drain("streak build");
    @(posedge clock); #1;
    for (int k = 0; k < 3; k++) begin
      gq.push_back(1'b1);
      sb.push_back(exp_t'{1'b1, 8'h3C});
    end
    gq.push_back(1'b0);
    sb.push_back(exp_t'{1'b0, 8'hA5});
    f_req = 1'b1; d_req = 1'b1;
    wait_grants("streak cleared");
    f_req = 1'b0; d_req = 1'b0;
    wait_drain("streak cleared");

    repeat (4) @(posedge clock);
    #1;
    check("final grant queue", 32'(gq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences the single 8-bit memory port and shares it between two requesters: the instruction-fetch stage and the load/store stage.
It replaces the ad-hoc fetch/stall interleaving in the controller with an explicit request/grant/valid handshake.
It generates the memory strobes (address, to_mem, mem_clock, mem_write) and returns read data to the owning requester.
Data (load/store) requests have priority, with a streak limit so fetch is never starved.

Parameters:
MEM_WAIT, 1, cycles between end of mem_clock pulse and capture of from_mem (legal range 1..15)
MAX_STREAK, 3, max consecutive data grants while fetch is pending before fetch is forced (legal range 1..15)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
f_req  input  1  fetch requests a read
f_addr  input  8  fetch address (PC)
f_grant  output  1  1-cycle pulse: fetch request accepted; f_addr may change after
f_valid  output  1  1-cycle pulse: f_rdata holds fetched byte
f_rdata  output  8  fetched instruction byte; holds until next fetch completion
d_req  input  1  load/store request
d_write  input  1  1 = store, 0 = load
d_addr  input  8  data address
d_wdata  input  8  store data
d_grant  output  1  1-cycle pulse: data request accepted
d_valid  output  1  1-cycle pulse: load data ready / store done
d_rdata  output  8  load data; unchanged by stores
address  output  8  memory address
to_mem  output  8  memory write data
from_mem  input  8  memory read data
mem_clock  output  1  memory strobe; memory acts on its rising edge
mem_write  output  1  write enable, stable for the whole access

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; streak=0; any in-flight access is abandoned with no valid pulse; mem_clock low the cycle after reset is sampled.
- State machine: IDLE -> STROBE -> WAIT -> IDLE. All outputs are registered.
- IDLE, no request: hold. address, to_mem and mem_write keep their last values; mem_clock=0.
- IDLE, request present at edge N:
  - Select the owner, latch its addr/write/wdata into address/mem_write/to_mem, set mem_clock=1, go to STROBE.
  - Owner's grant is high during cycle N+1 only.
  - Fetch accesses always have mem_write=0; to_mem is unchanged for fetches.
- Owner selection:
  - Only one request: grant it.
  - Both requests: data wins, unless streak==MAX_STREAK, in which case fetch wins.
- Streak counter:
  - Increments on a data grant while f_req=1, saturating at MAX_STREAK.
  - Clears on a fetch grant, or on any IDLE-cycle edge where f_req=0.
- STROBE (1 cycle): at next edge, mem_clock<=0, load wait counter with MEM_WAIT, go to WAIT.
- WAIT:
  - Decrement the counter each edge.
  - At the edge where the counter reaches 1:
    - Load: latch from_mem into the owner's rdata.
    - Store: leave d_rdata unchanged.
    - Pulse the owner's valid for the following cycle; go to IDLE.
- Latency: grant in cycle N+1; valid in cycle N+2+MEM_WAIT, and the FSM is already in IDLE that cycle.
  - A request present then is sampled immediately; back-to-back throughput is one access per 2+MEM_WAIT cycles.
- address, mem_write and to_mem are stable from STROBE until the next acceptance, i.e. constant across the mem_clock rising edge.
- Requester inputs are ignored outside IDLE. A requester must hold req, addr and data until its grant.
  - Deasserting req before grant withdraws the request, with no side effect.
- A requester may re-assert req in the same cycle as its valid pulse.
- f_grant and d_grant are never high together; the same holds for f_valid and d_valid.

Test Plan:
- Single fetch, MEM_WAIT=1, mem[0x10]=0xA5: f_req=1, f_addr=0x10 at edge 0 -> f_grant in cycle 1; mem_clock=1 in cycle 1 only; address=0x10, mem_write=0; f_valid in cycle 3 with f_rdata=0xA5.
- Store then load, MEM_WAIT=2:
  - Store: d_write=1, d_addr=0x20, d_wdata=0x3C -> mem_write=1, to_mem=0x3C during strobe; d_valid at cycle 4; d_rdata unchanged.
  - Load of 0x20 -> d_rdata=0x3C.
- Contention: f_req and d_req both held high continuously, MAX_STREAK=3 -> grant order D,D,D,F,D,D,D,F; no cycle has both grants.
- Fetch idle clears streak: two data grants, one IDLE edge with f_req=0, then continuous contention -> three data grants before the first fetch grant.
- Reset mid-access: reset asserted during WAIT -> next cycle mem_clock=0 and all outputs 0; no valid pulse; a new f_req after reset completes normally.
- Withdrawn request: d_req pulsed 1 cycle while a fetch is in WAIT -> no d_grant, no memory write; the fetch completes unaffected.
